// File: rtl/sata_device_oob.sv
// sata_device_oob: device-side SATA OOB responder and link bring-up sequencer.
// Define SATA_DEVICE_OOB_TIMEOUT_EN to build the COMWAKE/ALIGN retry timeouts.
module sata_device_oob #(
  parameter int COMINIT_DELAY   = 16,
  parameter int COMWAKE_TIMEOUT = 65536,
  parameter int ALIGN_TIMEOUT   = 65536,
  parameter int NONALIGN_COUNT  = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_comreset_det,
  input  logic       rx_comwake_det,
  input  logic       tx_com_done,
  input  logic       rx_valid,
  input  logic       rx_align,
  output logic       tx_cominit,
  output logic       tx_comwake,
  output logic [1:0] tx_prim,
  output logic       ready,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_COMINIT  = 3'd1,
    SEND_COMINIT  = 3'd2,
    AWAIT_COMWAKE = 3'd3,
    SEND_COMWAKE  = 3'd4,
    SEND_ALIGN    = 3'd5,
    SEND_SYNC     = 3'd6,
    READY         = 3'd7
  } state_e;

  localparam int MAX_AB_P    = (COMINIT_DELAY > COMWAKE_TIMEOUT) ? COMINIT_DELAY : COMWAKE_TIMEOUT;
  localparam int DWELL_MAX_P = (MAX_AB_P > ALIGN_TIMEOUT) ? MAX_AB_P : ALIGN_TIMEOUT;
  localparam int DW          = $clog2(DWELL_MAX_P + 1);

  localparam logic [DW-1:0] DWELL_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DWELL_SAT  = {DW{1'b1}};
  localparam logic [DW-1:0] DWELL_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] CI_LAST    = DW'(COMINIT_DELAY - 1);
`ifdef SATA_DEVICE_OOB_TIMEOUT_EN
  localparam logic [DW-1:0] CW_LAST    = DW'(COMWAKE_TIMEOUT - 1);
  localparam logic [DW-1:0] AL_LAST    = DW'(ALIGN_TIMEOUT - 1);
`endif
  localparam logic [3:0]    NA_TARGET  = 4'(NONALIGN_COUNT);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [DW-1:0]   dwell_r;
  logic [3:0]      sync_cnt_r;
  logic [3:0]      sync_cnt_nxt_s;
  logic            done_ok_s;
  logic            enter_s;
  logic            tx_cominit_r;
  logic            tx_comwake_r;
  logic [1:0]      tx_prim_r;
  logic            ready_r;

  function automatic logic [1:0] prim_for(input state_e s);
    case (s)
      SEND_ALIGN:      prim_for = 2'd1;
      SEND_SYNC, READY: prim_for = 2'd2;
      default:         prim_for = 2'd0;
    endcase
  endfunction

  // A burst-done only counts after the request cycle, so a stale done from an aborted burst is dropped.
  assign done_ok_s = tx_com_done && (dwell_r != DWELL_ZERO);
  assign enter_s   = rx_comreset_det || (state_nxt_s != state_r);

  // Consecutive valid non-ALIGN count; rx_valid gaps hold, an ALIGN clears.
  always_comb begin
    sync_cnt_nxt_s = sync_cnt_r;
    if (state_r != SEND_SYNC) begin
      sync_cnt_nxt_s = 4'd0;
    end else if (rx_valid && rx_align) begin
      sync_cnt_nxt_s = 4'd0;
    end else if (rx_valid && (sync_cnt_r != 4'd15)) begin
      sync_cnt_nxt_s = sync_cnt_r + 4'd1;
    end else begin
      sync_cnt_nxt_s = sync_cnt_r;
    end
  end

  // Next-state decode; COMRESET overrides every other transition and timeout.
  always_comb begin
    state_nxt_s = state_r;
    if (rx_comreset_det) begin
      state_nxt_s = WAIT_COMINIT;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        WAIT_COMINIT: begin
          if (dwell_r == CI_LAST) state_nxt_s = SEND_COMINIT;
          else                    state_nxt_s = WAIT_COMINIT;
        end
        SEND_COMINIT: begin
          if (done_ok_s) state_nxt_s = AWAIT_COMWAKE;
          else           state_nxt_s = SEND_COMINIT;
        end
        AWAIT_COMWAKE: begin
          if (rx_comwake_det)         state_nxt_s = SEND_COMWAKE;
`ifdef SATA_DEVICE_OOB_TIMEOUT_EN
          else if (dwell_r == CW_LAST) state_nxt_s = SEND_COMINIT;
`endif
          else                        state_nxt_s = AWAIT_COMWAKE;
        end
        SEND_COMWAKE: begin
          if (done_ok_s) state_nxt_s = SEND_ALIGN;
          else           state_nxt_s = SEND_COMWAKE;
        end
        SEND_ALIGN: begin
          if (rx_valid && rx_align)   state_nxt_s = SEND_SYNC;
`ifdef SATA_DEVICE_OOB_TIMEOUT_EN
          else if (dwell_r == AL_LAST) state_nxt_s = SEND_COMINIT;
`endif
          else                        state_nxt_s = SEND_ALIGN;
        end
        SEND_SYNC: begin
          if (sync_cnt_nxt_s == NA_TARGET) state_nxt_s = READY;
          else                             state_nxt_s = SEND_SYNC;
        end
        READY:   state_nxt_s = READY;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, saturating dwell counter, SYNC counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= IDLE;
      dwell_r      <= DWELL_ZERO;
      sync_cnt_r   <= 4'd0;
      tx_cominit_r <= 1'b0;
      tx_comwake_r <= 1'b0;
      tx_prim_r    <= 2'd0;
      ready_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      if (enter_s)                    dwell_r <= DWELL_ZERO;
      else if (dwell_r != DWELL_SAT)  dwell_r <= dwell_r + DWELL_ONE;
      else                            dwell_r <= dwell_r;
      sync_cnt_r   <= enter_s ? 4'd0 : sync_cnt_nxt_s;
      tx_cominit_r <= enter_s && (state_nxt_s == SEND_COMINIT);
      tx_comwake_r <= enter_s && (state_nxt_s == SEND_COMWAKE);
      tx_prim_r    <= prim_for(state_nxt_s);
      ready_r      <= (state_nxt_s == READY);
    end
  end

  assign tx_cominit = tx_cominit_r;
  assign tx_comwake = tx_comwake_r;
  assign tx_prim    = tx_prim_r;
  assign ready      = ready_r;
  assign state      = state_r;

endmodule

// File: tb/tb_sata_device_oob.sv
// Self-checking bench for sata_device_oob: vector table, hand-written corner
// sequences and a randomized run against a cycle-level reference model.
module tb_sata_device_oob;

  localparam int CD  = 16;
  localparam int CWT = 64;
  localparam int AT  = 128;
  localparam int NA  = 3;
`ifdef SATA_DEVICE_OOB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // input vector bits: {sys_rst, comreset, comwake, com_done, rx_valid, rx_align}
  localparam logic [5:0] Q   = 6'b000000;
  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] CR  = 6'b010000;
  localparam logic [5:0] CW  = 6'b001000;
  localparam logic [5:0] DN  = 6'b000100;
  localparam logic [5:0] VL  = 6'b000010;
  localparam logic [5:0] AL  = 6'b000001;

  logic       sys_clk;
  logic       sys_rst, rx_comreset_det, rx_comwake_det, tx_com_done, rx_valid, rx_align;
  logic       tx_cominit, tx_comwake, ready;
  logic [1:0] tx_prim;
  logic [2:0] state;

  int n_checks, n_errors, cyc, n_ci, n_cw;
  int prim_q[$];
  int m_phase, m_age, m_syncs;

  typedef struct {
    logic [5:0] in;
    int         gap;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [23];

  sata_device_oob #(
    .COMINIT_DELAY(CD), .COMWAKE_TIMEOUT(CWT), .ALIGN_TIMEOUT(AT), .NONALIGN_COUNT(NA)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_comreset_det(rx_comreset_det),
    .rx_comwake_det(rx_comwake_det), .tx_com_done(tx_com_done), .rx_valid(rx_valid),
    .rx_align(rx_align), .tx_cominit(tx_cominit), .tx_comwake(tx_comwake),
    .tx_prim(tx_prim), .ready(ready), .state(state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic logic [7:0] pk(input int st, input int pr, input int rd, input int ci, input int cw);
    return {st[2:0], pr[1:0], rd[0], ci[0], cw[0]};
  endfunction

  function automatic vec_t mk(input logic [5:0] in, input int gap, input logic [7:0] exp);
    vec_t v;
    v.in = in; v.gap = gap; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] dut_out();
    return {state, tx_prim, ready, tx_cominit, tx_comwake};
  endfunction

  // Reference: phase number, cycles since entering it, and SYNCs seen since the last ALIGN.
  function automatic logic [7:0] model_out();
    int pr;
    pr = (m_phase == 5) ? 1 : (m_phase >= 6) ? 2 : 0;
    return pk(m_phase, pr, int'(m_phase == 7), int'(m_phase == 2 && m_age == 0),
              int'(m_phase == 4 && m_age == 0));
  endfunction

  task automatic model_step(input logic [5:0] in);
    int np;
    if (in[5]) begin
      m_phase = 0; m_age = 0; m_syncs = 0;
    end else begin
      np = m_phase;
      if (in[4]) np = 1;
      else case (m_phase)
        1: if (m_age == CD - 1) np = 2;
        2: if (in[2] && m_age > 0) np = 3;
        3: if (in[3]) np = 4; else if (TO_EN && m_age == CWT - 1) np = 2;
        4: if (in[2] && m_age > 0) np = 5;
        5: if (in[1] && in[0]) np = 6; else if (TO_EN && m_age == AT - 1) np = 2;
        6: begin
          if (in[1]) m_syncs = in[0] ? 0 : m_syncs + 1;
          if (m_syncs >= NA) np = 7;
        end
        default: ;
      endcase
      if (np != m_phase || in[4]) begin
        m_age = 0; m_syncs = 0;
      end else begin
        m_age++;
      end
      m_phase = np;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic [5:0] in);
    {sys_rst, rx_comreset_det, rx_comwake_det, tx_com_done, rx_valid, rx_align} = in;
    @(posedge sys_clk);
    model_step(in);
    @(negedge sys_clk);
    cyc++;
    if (tx_cominit === 1'b1) n_ci++;
    if (tx_comwake === 1'b1) n_cw++;
    if (prim_q.size() == 0 || prim_q[prim_q.size()-1] != int'(tx_prim)) prim_q.push_back(int'(tx_prim));
    check("model", {24'd0, dut_out()}, {24'd0, model_out()});
  endtask

  task automatic wait_cominit(input string tag);
    int n;
    n = 0;
    while (tx_cominit !== 1'b1 && n < 200) begin
      cycle(Q);
      n++;
    end
    check(tag, tx_cominit, 1);
  endtask

  task automatic reach_comwake();
    cycle(RST); cycle(CR);
    wait_cominit("reach_ci");
    cycle(Q); cycle(DN); cycle(CW);
    check("reach_comwake", state, 4);
  endtask

  task automatic reach_align();
    reach_comwake();
    cycle(Q); cycle(DN);
    check("reach_align", state, 5);
  endtask

  task automatic bringup(input string tag);
    int t_cr, code;
    repeat (10) cycle(Q);
    t_cr = cyc;
    cycle(CR);
    check({tag, "_cr_next"}, {state, tx_prim, ready}, {3'd1, 2'd0, 1'b0});
    n_ci = 0; n_cw = 0;
    prim_q.delete();
    prim_q.push_back(int'(tx_prim));
    wait_cominit({tag, "_ci_seen"});
    check({tag, "_ci_cycle"}, cyc - t_cr, 1 + CD);
    repeat (20) cycle(Q);
    cycle(DN);
    check({tag, "_await"}, state, 3);
    repeat (29) cycle(Q);
    cycle(CW);
    check({tag, "_comwake"}, {state, tx_comwake}, {3'd4, 1'b1});
    repeat (20) cycle(Q);
    cycle(DN);
    check({tag, "_align"}, {state, tx_prim}, {3'd5, 2'd1});
    repeat (40) cycle(Q);
    cycle(VL | AL);
    check({tag, "_sync"}, {state, tx_prim}, {3'd6, 2'd2});
    cycle(VL); check({tag, "_sync1"}, ready, 0);
    cycle(VL); check({tag, "_sync2"}, ready, 0);
    cycle(VL); check({tag, "_ready"}, {state, tx_prim, ready}, {3'd7, 2'd2, 1'b1});
    check({tag, "_n_cominit"}, n_ci, 1);
    check({tag, "_n_comwake"}, n_cw, 1);
    code = 0;
    foreach (prim_q[i]) code = code * 16 + prim_q[i] + 1;
    check({tag, "_prim_seq"}, code, 32'h123);
  endtask

  logic [5:0] rin;
  int t_cr, n, n3, bad;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; n_ci = 0; n_cw = 0;
    m_phase = 0; m_age = 0; m_syncs = 0;
    {sys_rst, rx_comreset_det, rx_comwake_det, tx_com_done, rx_valid, rx_align} = RST;

    tbl[0]  = mk(RST,     0,  pk(0, 0, 0, 0, 0));
    tbl[1]  = mk(Q,       5,  pk(0, 0, 0, 0, 0));
    tbl[2]  = mk(CR,      0,  pk(1, 0, 0, 0, 0));
    tbl[3]  = mk(Q,       14, pk(1, 0, 0, 0, 0));
    tbl[4]  = mk(Q,       0,  pk(2, 0, 0, 1, 0));
    tbl[5]  = mk(DN,      0,  pk(2, 0, 0, 0, 0));
    tbl[6]  = mk(DN,      0,  pk(3, 0, 0, 0, 0));
    tbl[7]  = mk(CW,      0,  pk(4, 0, 0, 0, 1));
    tbl[8]  = mk(DN,      0,  pk(4, 0, 0, 0, 0));
    tbl[9]  = mk(Q,       3,  pk(4, 0, 0, 0, 0));
    tbl[10] = mk(DN,      0,  pk(5, 1, 0, 0, 0));
    tbl[11] = mk(VL,      0,  pk(5, 1, 0, 0, 0));
    tbl[12] = mk(VL | AL, 0,  pk(6, 2, 0, 0, 0));
    tbl[13] = mk(VL,      0,  pk(6, 2, 0, 0, 0));
    tbl[14] = mk(Q,       2,  pk(6, 2, 0, 0, 0));
    tbl[15] = mk(VL,      0,  pk(6, 2, 0, 0, 0));
    tbl[16] = mk(VL | AL, 0,  pk(6, 2, 0, 0, 0));
    tbl[17] = mk(VL,      0,  pk(6, 2, 0, 0, 0));
    tbl[18] = mk(VL,      0,  pk(6, 2, 0, 0, 0));
    tbl[19] = mk(VL,      0,  pk(7, 2, 1, 0, 0));
    tbl[20] = mk(Q,       10, pk(7, 2, 1, 0, 0));
    tbl[21] = mk(CR,      0,  pk(1, 0, 0, 0, 0));
    tbl[22] = mk(RST,     0,  pk(0, 0, 0, 0, 0));

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].in);
      repeat (tbl[i].gap) cycle(Q);
      check($sformatf("vec%0d", i), {24'd0, dut_out()}, {24'd0, tbl[i].exp});
    end

    // nominal bring-up from reset, then link drop from READY
    cycle(RST);
    bringup("nominal");
    bringup("drop");

    // no COMWAKE after COMINIT
    cycle(RST); cycle(CR);
    wait_cominit("to_ci1");
    cycle(Q); cycle(DN);
    check("to_await", state, 3);
`ifdef SATA_DEVICE_OOB_TIMEOUT_EN
    n3 = 0; n = 0;
    while (tx_cominit !== 1'b1 && n < 300) begin
      if (state == 3'd3) n3++;
      cycle(Q);
      n++;
    end
    check("to_retry_ci", {state, tx_cominit}, {3'd2, 1'b1});
    check("to_dwell", n3, CWT);
`else
    bad = 0;
    repeat (10000) begin
      cycle(Q);
      if (state !== 3'd3) bad++;
    end
    check("to_hold", bad, 0);
`endif

    // SYNC qualification: SYNC SYNC ALIGN then three SYNCs with rx_valid gaps
    reach_align();
    cycle(VL | AL);
    check("sq_enter", state, 6);
    cycle(VL); cycle(VL);
    check("sq_two", ready, 0);
    cycle(VL | AL); cycle(VL);
    check("sq_after_align", ready, 0);
    cycle(Q); cycle(Q); cycle(VL);
    check("sq_gap", ready, 0);
    cycle(Q); cycle(VL);
    check("sq_final", {state, ready}, {3'd7, 1'b1});

    // COMRESET during SEND_COMWAKE with a stale done two cycles later
    reach_comwake();
    cycle(Q);
    t_cr = cyc;
    cycle(CR);
    check("abort_state", state, 1);
    cycle(Q); cycle(DN);
    check("abort_done_ignored", state, 1);
    wait_cominit("abort_ci");
    check("abort_ci_cycle", cyc - t_cr, 1 + CD);

    // sys_rst in SEND_ALIGN
    reach_align();
    cycle(RST);
    check("rst_outputs", {24'd0, dut_out()}, 32'd0);
    bad = 0;
    repeat (50) begin
      cycle(Q);
      if (dut_out() !== 8'd0) bad++;
    end
    check("rst_stays_idle", bad, 0);

    // randomized run against the reference model
    cycle(RST);
    for (int i = 0; i < 8000; i++) begin
      rin    = Q;
      rin[5] = ($urandom_range(0, 4999) == 0);
      rin[4] = ($urandom_range(0, 1499) == 0);
      rin[3] = ($urandom_range(0, 29) == 0);
      rin[2] = ($urandom_range(0, 7) == 0);
      rin[1] = ($urandom_range(0, 1) == 1);
      rin[0] = ($urandom_range(0, 3) == 0);
      cycle(rin);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
